instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Front-end stage directly upstream of the instruction decoder.
- Owns the program counter and issues word reads to a synchronous instruction memory.
- Presents each returned 16-bit instruction with a valid flag to the decoder, and absorbs stall, branch-redirect and halt events from downstream.
- A one-entry hold buffer keeps an in-flight word from being lost when a stall arrives.

Parameters:
- PC_WIDTH, 16, width of the PC and instruction-memory word address.
- RESET_PC, 0, address of the first fetch after start.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts fetching from IDLE.
- stall  in  1  downstream cannot accept the presented instruction this cycle.
- branch_taken  in  1  redirect pulse from the branch unit.
- branch_target  in  PC_WIDTH  redirect address, sampled when branch_taken=1.
- imem_addr  out  PC_WIDTH  read address, equal to the current PC.
- imem_rd_en  out  1  read strobe; imem_rdata is valid one cycle later.
- imem_rdata  in  16  instruction word returned by memory.
- instr  out  16  instruction to the decoder; 0 when instr_valid=0.
- instr_pc  out  PC_WIDTH  address of instr; 0 when instr_valid=0.
- instr_valid  out  1  instr is meaningful this cycle.
- halted  out  1  HALT has retired; fetch is stopped.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, pc=RESET_PC, inflight=0, hold_valid=0.
  - Outputs: imem_rd_en=0, instr_valid=0, halted=0, instr=0, instr_pc=0.
  - rst takes priority over every other input and may arrive in any state, including mid-operation.
- States:
  - IDLE: no reads are issued. start=1 moves to FETCH next cycle; all other inputs are ignored.
  - FETCH: normal operation.
  - HALTED: halted=1, imem_rd_en=0, instr_valid=0. Only rst leaves this state; start is ignored.
- Read issue (FETCH only):
  - imem_rd_en = ~stall & ~hold_valid & ~branch_taken & ~halt_accept.
  - When a read issues: inflight<=1, inflight_pc<=pc, pc<=pc+1 (word-addressed; wraps from 2^PC_WIDTH-1 to 0).
  - When no read issues: inflight<=0.
- Presentation:
  - If hold_valid=1: instr/instr_pc come from the hold buffer.
  - Otherwise, if inflight=1: instr=imem_rdata (combinational) and instr_pc=inflight_pc.
  - instr_valid = hold_valid | inflight.
  - Latency: address issued in cycle N appears as instr in cycle N+1.
- accept = instr_valid & ~stall.
- Hold buffer:
  - inflight=1 and stall=1 → capture imem_rdata and inflight_pc; hold_valid<=1.
  - Hold is released (hold_valid<=0) on accept.
  - Invariant: hold_valid=1 implies inflight=0. Verification asserts this.
- Branch (branch_taken=1 in FETCH):
  - pc<=branch_target; no read is issued that cycle; hold_valid<=0.
  - The currently presented word is still presented that cycle, and may be accepted.
  - The first target read issues the following cycle.
  - branch_taken is honoured even when stall=1.
- Halt:
  - halt_accept = accept & (instr[15:11]==5'b00000).
  - On halt_accept: no read is issued that cycle; state<=HALTED; hold_valid<=0; pc is not advanced.
  - halt_accept overrides a simultaneous branch_taken.
- Simultaneous start and rst: reset wins, state stays IDLE.
- stall, branch_taken and branch_target are don't-care outside FETCH.

Test Plan:
1. Straight-line fetch: rst, then start; memory holds A[0..3]=16'h2101,16'h2202,16'h5123,16'h0000 → instr_valid high from cycle 2 after start, instr sequence 2101,2202,5123,0000 with instr_pc 0,1,2,3. Then halted=1, imem_rd_en=0, and no further reads.
2. Stall with hold: assert stall for 3 cycles while instr=16'h2202 (pc 1) is in flight → instr stays 2202 and instr_pc stays 1 with instr_valid=1 throughout; no reads issue. After stall drops, 2202 is accepted once and the next read is address 2. No duplicate or lost words.
3. Branch redirect: branch_taken=1 with branch_target=16'h0040 while word at pc 5 is presented → imem_addr=16'h0040 on the next cycle's read; next valid instr_pc=0x40. Words from pc 6 or later never appear.
4. Branch during stall with hold_valid=1, target 16'h0010 → hold is discarded; after stall drops, first valid instr_pc=0x10.
5. PC wrap: RESET_PC=16'hFFFE, straight-line fetch → imem_addr sequence FFFE, FFFF, 0000, 0001.
6. Reset mid-operation: rst during FETCH with hold_valid=1 → next cycle all outputs are at reset values and state is IDLE. start then fetches from RESET_PC. Also confirm start is ignored while halted=1.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Front-end fetch stage sitting directly upstream of the instruction decoder.
// Owns the program counter, issues word reads to a synchronous instruction
// memory (data returns one cycle after the read strobe) and presents each
// returned 16-bit word to the decoder together with its address.
//
// Downstream events:
//   stall        - decoder cannot take the presented word this cycle. A word
//                  that is in flight when the stall arrives is parked in a
//                  one-entry hold buffer so it is not lost.
//   branch_taken - redirect to branch_target. The word presented this cycle
//                  may still be accepted; everything fetched after it is
//                  dropped and the target read issues on the following cycle.
//   HALT         - any accepted word whose opcode field [15:11] is zero.
//                  Fetch stops and only rst restarts the stage.
//
// Ports:
//   clk            in   system clock, rising-edge
//   rst            in   synchronous, active-high reset
//   start          in   one-cycle pulse, leaves IDLE
//   stall          in   downstream back-pressure
//   branch_taken   in   redirect pulse
//   branch_target  in   redirect address (PC_WIDTH)
//   imem_addr      out  read address = current PC (PC_WIDTH)
//   imem_rd_en     out  read strobe; imem_rdata valid next cycle
//   imem_rdata     in   instruction word from memory (16)
//   instr          out  instruction to decoder, 0 when not valid (16)
//   instr_pc       out  address of instr, 0 when not valid (PC_WIDTH)
//   instr_valid    out  instr is meaningful this cycle
//   halted         out  HALT retired, fetch stopped
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int                   PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_rd_en,
  input  logic [15:0]         imem_rdata,
  output logic [15:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  output logic                halted
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [4:0] HALT_OPCODE = 5'b00000;

  state_t                state;
  logic [PC_WIDTH-1:0]   pc;

  // A read issued last cycle whose data is on imem_rdata now.
  logic                  inflight;
  logic [PC_WIDTH-1:0]   inflight_pc;

  // Parked copy of an in-flight word that met a stall.
  logic                  hold_valid;
  logic [15:0]           hold_instr;
  logic [PC_WIDTH-1:0]   hold_pc;

  logic                  in_fetch;
  logic                  accept;
  logic                  halt_accept;

  assign in_fetch = (state == ST_FETCH);

  // ---------------------------------------------------------------------------
  // Presentation mux. The hold buffer wins over the memory return path; by
  // construction the two are never both occupied.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    instr    = '0;
    instr_pc = '0;
    if (in_fetch && hold_valid) begin
      instr    = hold_instr;
      instr_pc = hold_pc;
    end else if (in_fetch && inflight) begin
      instr    = imem_rdata;
      instr_pc = inflight_pc;
    end
  end

  assign instr_valid = in_fetch & (hold_valid | inflight);
  assign accept      = instr_valid & ~stall;

  // A HALT only takes effect once the decoder actually takes it.
  assign halt_accept = accept & (instr[15:11] == HALT_OPCODE);

  // A new read is only useful when the decoder will be able to take its data
  // next cycle and the fetch stream is not being redirected or stopped.
  assign imem_rd_en = in_fetch & ~stall & ~hold_valid & ~branch_taken & ~halt_accept;
  assign imem_addr  = pc;

  assign halted = (state == ST_HALTED);

  // ---------------------------------------------------------------------------
  // State, PC, in-flight tracking and hold buffer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all sequential state, so every
      // register samples the pre-edge values of its neighbours.
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      hold_valid  <= 1'b0;
      // NOTE: the hold data registers are reset as well as their valid flag,
      // which keeps X out of instr/instr_pc in every simulation.
      hold_instr  <= '0;
      hold_pc     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (halt_accept) begin
            // HALT beats a simultaneous branch; the PC stays where it is.
            state      <= ST_HALTED;
            inflight   <= 1'b0;
            hold_valid <= 1'b0;
          end else if (branch_taken) begin
            // Redirect: drop anything not yet accepted, fetch target next.
            pc         <= branch_target;
            inflight   <= 1'b0;
            hold_valid <= 1'b0;
          end else begin
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
              inflight_pc <= pc;
              pc          <= pc + PC_WIDTH'(1);
            end

            // A stalled in-flight word would vanish with the next memory
            // cycle, so park it. Reads are blocked while parked, which keeps
            // hold_valid and inflight mutually exclusive.
            if (inflight && stall) begin
              hold_valid <= 1'b1;
              hold_instr <= imem_rdata;
              hold_pc    <= inflight_pc;
            end else if (accept) begin
              hold_valid <= 1'b0;
            end
          end
        end

        ST_HALTED: begin
          // Only rst leaves this state.
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
